// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - RV32 byte-addressed data memory, hardware clear after reset, fixed-latency responses
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned halfword/word accesses instead of force-aligning them.
module data_mem_pipe #(
   parameter int AddressWidth = 12,
   parameter int ReadLatency  = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [2:0]              req_funct3_i,
   input  logic [AddressWidth-1:0] req_addr_i,
   input  logic [31:0]             req_wdata_i,
   output logic                    rsp_valid_o,
   output logic [31:0]             rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    init_done_o
);
   localparam int IdxW  = AddressWidth - 2;
   localparam int Words = 2 ** IdxW;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state, state_nxt;
   logic [IdxW-1:0]   clr_cnt, clr_cnt_nxt;
   logic [31:0]       mem [Words];

   logic [IdxW-1:0]   idx;
   logic [1:0]        off_raw, off, size;
   logic              legal, err, accept, wr_en;
   logic [3:0]        be;
   logic [31:0]       wlane, rword, shifted, ld_data, rsp_data;

   logic [ReadLatency-1:0] pipe_v, pipe_e;
   logic [31:0]            pipe_d [ReadLatency];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      req_ready_o = 1'b0;
      init_done_o = 1'b0;
      case (state)
         CLEAR: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == {IdxW{1'b1}}) state_nxt = RUN;
         end
         RUN: begin
            req_ready_o = 1'b1;
            init_done_o = 1'b1;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign idx     = req_addr_i[AddressWidth-1:2];
   assign off_raw = req_addr_i[1:0];
   assign size    = req_funct3_i[1:0];
   assign legal   = req_we_i ? (!req_funct3_i[2] && size != 2'b11)
                             : (size != 2'b11 && req_funct3_i != 3'b110);

`ifdef DMEM_MISALIGN_FAULT_EN
   assign off = off_raw;
   assign err = !legal || (size == 2'b01 && off_raw[0]) || (size == 2'b10 && off_raw != 2'b00);
`else
   assign off = (size == 2'b10) ? 2'b00 : (size == 2'b01) ? {off_raw[1], 1'b0} : off_raw;
   assign err = !legal;
`endif

   assign accept = req_valid_i && req_ready_o;
   assign wr_en  = accept && req_we_i && !err;

   always_comb begin
      be    = 4'b1111;
      wlane = req_wdata_i;
      case (size)
         2'b00: begin
            be    = 4'b0001 << off;
            wlane = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Reads see the array as left by the previous edge, so a store followed by a load needs no bypass.
   assign rword   = mem[idx];
   assign shifted = rword >> {off, 3'b000};

   always_comb begin
      ld_data = rword;
      case (size)
         2'b00:   ld_data = {{24{!req_funct3_i[2] && shifted[7]}}, shifted[7:0]};
         2'b01:   ld_data = {{16{!req_funct3_i[2] && shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

   assign rsp_data = (req_we_i || err) ? 32'h0 : ld_data;

   always_ff @(posedge clk_i) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < ReadLatency; i++) pipe_d[i] <= '0;
      end else begin
         pipe_v[0] <= accept;
         pipe_e[0] <= accept && err;
         pipe_d[0] <= accept ? rsp_data : 32'h0;
         for (int i = 1; i < ReadLatency; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign rsp_valid_o = pipe_v[ReadLatency-1];
   assign rsp_err_o   = pipe_e[ReadLatency-1];
   assign rsp_rdata_o = pipe_d[ReadLatency-1];
endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Byte-addressed RV32 data memory with a valid/ready request port and a fixed-latency response port.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW, with byte-lane steering from the low address bits.
- Has a configurable read pipeline depth and flags misaligned or illegal accesses.
- After every reset, a hardware clear sequence zeroes the whole array before requests are accepted.
- Sits between the core's load/store unit and the memory array.

Parameters:
- AddressWidth, 12: byte-address width; array holds 2**(AddressWidth-2) 32-bit words.
- ReadLatency, 1: cycles from request acceptance to rsp_valid_o; legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request; 0 during clear.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32 load/store funct3.
- req_addr_i  in  AddressWidth  byte address.
- req_wdata_i  in  32  store data, taken from the low bits.
- rsp_valid_o  out  1  response valid for exactly one cycle.
- rsp_rdata_o  out  32  formatted load data; 0 for stores and errors.
- rsp_err_o  out  1  access faulted; qualified by rsp_valid_o.
- init_done_o  out  1  clear sequence complete.

Behaviour:
- Reset (async, rst_i=1): FSM to CLEAR, clear counter to 0, all pipeline valids to 0. Outputs: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, init_done_o=0.
- A request arriving during reset is dropped with no response.
- FSM states:
  - CLEAR: write 0 to word[counter] each cycle; counter+1. After the last word (counter = 2**(AddressWidth-2)-1), go to RUN next cycle.
  - RUN: init_done_o=1, req_ready_o=1 permanently.
  - There is no other exit from RUN except rst_i.
- Acceptance: req_valid_i & req_ready_o at a rising edge. One request per cycle; no backpressure on responses.
- Addressing: word index = req_addr_i[AddressWidth-1:2]; byte offset = req_addr_i[1:0].
- Loads:
  - LB/LBU select byte lane offset*8. LH/LHU select halfword lane offset[1]*16. LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB writes only byte lane [offset]; SH writes halfword lane [offset[1]]; SW writes the whole word.
  - Unwritten lanes keep their values.
  - The array is updated on the acceptance edge.
- Illegal funct3: loads 011/110/111, or stores other than 000/001/010.
  - Response has rsp_err_o=1 and rdata=0.
  - Illegal stores do not write.
- Latency:
  - The acceptance edge is cycle 0; rsp_valid_o is high in cycle ReadLatency, for exactly one cycle.
  - Stores also respond, with rdata=0 and err as computed.
  - Responses leave in request order; back-to-back requests give back-to-back responses.
- Read-after-write: a load accepted the cycle after a store to the same word returns the post-store contents, with no stall.
- Outputs are registered. rsp_rdata_o/rsp_err_o return to 0 in any cycle where rsp_valid_o=0.
- Reset mid-operation:
  - In-flight responses are discarded and the clear restarts from word 0.
  - Stores already accepted are overwritten by the clear.

Optional Feature:
- Macro: DMEM_MISALIGN_FAULT_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, produce rsp_err_o=1 and rdata=0.
  - A misaligned store performs no write.
- Undefined:
  - Misalignment is never faulted. Offending low address bits are forced to the natural alignment: bit 0 cleared for halfword, bits 1:0 cleared for word.
  - The access then proceeds normally; rsp_err_o is raised only for illegal funct3.

Test Plan:
- Clear sequence, AddressWidth=6 (16 words): release rst_i.
  - Expect req_ready_o=0 for 16 cycles, then 1 with init_done_o=1.
  - LW of any address then returns 0x00000000.
- SW 0x8000_7F80 to 0x10, then:
  - LB 0x10 -> 0xFFFFFF80.
  - LBU 0x11 -> 0x0000007F.
  - LH 0x12 -> 0xFFFF8000.
  - LHU 0x10 -> 0x00007F80.
  - ReadLatency=3: each rsp_valid_o appears exactly 3 cycles after its accept.
- Partial stores on word 0x20 (initially 0x11223344):
  - SB 0xAA to 0x21 -> LW 0x20 = 0x1122AA44.
  - SH 0xBEEF to 0x22 -> LW 0x20 = 0xBEEFAA44.
- Back-to-back SW 0xCAFEF00D to 0x40, then LW 0x40 next cycle (ReadLatency=1):
  - Two consecutive rsp_valid_o cycles.
  - Second response has rdata 0xCAFEF00D.
- Faults, DMEM_MISALIGN_FAULT_EN defined:
  - SW to 0x42 -> rsp_err_o=1, and word 0x40 is unchanged.
  - Load funct3=011 -> rsp_err_o=1, rdata=0.
  - Without the macro, the same SW writes word 0x40 with err=0.
- Assert rst_i with 2 loads in flight (ReadLatency=2):
  - No rsp_valid_o is ever produced for them.
  - The clear restarts, and a pre-reset nonzero word reads 0 after init_done_o.
